// File: rtl/im_compression_pkg.sv
// ----------------------------------------------------------------------------
// im_compression_pkg
// Shared types and helpers for the tile compression controller and engine.
//   t_cmp_ctrl_state : sequencer state encoding
//   t_cmp_ctrl_dbg   : debug view of the sequencer (state + sampled engine busy)
//   out_dim()        : output grid dimension for an input dimension and tile size
//   cnt_w()          : counter width able to hold 0..n-1 (never below 1 bit)
// ----------------------------------------------------------------------------
package im_compression_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4
    } t_cmp_ctrl_state;

    typedef struct packed {
        t_cmp_ctrl_state state;
        logic            engine_busy;
    } t_cmp_ctrl_dbg;

    function automatic int out_dim(input int in_dim, input int area);
        return in_dim / area;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/im_tile_addr_gen.sv
// ----------------------------------------------------------------------------
// im_tile_addr_gen
// Tile walker for the output grid in raster order. Tracks column, row, the
// input address of the current tile row (row_base) and the top-left input
// address of the current tile (tile_ptr). Only incremental adds are used.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   load_i         restart the walk at base_i (col=row=0)
//   base_i         input-buffer address of pixel (0,0)
//   advance_i      step to the next tile (ignored on the last tile)
//   tile_ptr_o     top-left input address of the current tile
//   last_o         current tile is the bottom-right tile of the grid
// ----------------------------------------------------------------------------
module im_tile_addr_gen
    import im_compression_pkg::*;
#(
    parameter int pIN_IM_WIDTH = 640,
    parameter int pAREA_WIDTH  = 4,
    parameter int pAREA_HEIGHT = 4,
    parameter int pOUT_W       = 160,
    parameter int pOUT_H       = 120,
    parameter int pADDR_W      = 19
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [pADDR_W-1:0] base_i,
    input  logic               advance_i,
    output logic [pADDR_W-1:0] tile_ptr_o,
    output logic               last_o
);

    localparam int lpCOL_W = cnt_w(pOUT_W);
    localparam int lpROW_W = cnt_w(pOUT_H);

    localparam logic [lpCOL_W-1:0] lpCOL_LAST = lpCOL_W'(pOUT_W - 1);
    localparam logic [lpROW_W-1:0] lpROW_LAST = lpROW_W'(pOUT_H - 1);
    localparam logic [pADDR_W-1:0] lpCOL_STEP = pADDR_W'(pAREA_WIDTH);
    // One tile row down in the input frame.
    localparam logic [pADDR_W-1:0] lpROW_STEP = pADDR_W'(pAREA_HEIGHT * pIN_IM_WIDTH);

    logic [lpCOL_W-1:0] col_q,      col_d;
    logic [lpROW_W-1:0] row_q,      row_d;
    logic [pADDR_W-1:0] row_base_q, row_base_d;
    logic [pADDR_W-1:0] tile_ptr_q, tile_ptr_d;
    logic               last;

    assign last = (col_q == lpCOL_LAST) && (row_q == lpROW_LAST);

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        tile_ptr_d = tile_ptr_q;
        if (load_i) begin
            col_d      = '0;
            row_d      = '0;
            row_base_d = base_i;
            tile_ptr_d = base_i;
        end else if (advance_i && !last) begin
            if (col_q != lpCOL_LAST) begin
                col_d      = col_q + lpCOL_W'(1);
                tile_ptr_d = tile_ptr_q + lpCOL_STEP;
            end else begin
                // Row wrap: the next tile starts at the new row base.
                col_d      = '0;
                row_d      = row_q + lpROW_W'(1);
                row_base_d = row_base_q + lpROW_STEP;
                tile_ptr_d = row_base_q + lpROW_STEP;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            tile_ptr_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            tile_ptr_q <= tile_ptr_d;
        end
    end

    assign tile_ptr_o = tile_ptr_q;
    assign last_o     = last;

endmodule

// File: rtl/im_compression_ctrl.sv
// ----------------------------------------------------------------------------
// im_compression_ctrl
// Frame-level sequencer for the 4x4 tile compression engine. On an accepted
// frame start it walks the output grid in raster order, issues one engine job
// per output pixel, waits for the engine result and writes it to the output
// frame buffer.
// Ports:
//   iclk, irst      clock, asynchronous active-high reset
//   istart_frame    pulse: begin compressing a frame (ignored while busy)
//   iframe_base     input address of pixel (0,0), latched on accepted start
//   iabort          level: abandon the current frame (wins over start)
//   oframe_busy     high from accepted start until done/abort
//   oframe_done     1-cycle pulse at frame end (also after timeout)
//   oerr_timeout    sticky engine timeout flag, cleared on next accepted start
//   ostart_work     engine job request
//   ostart_ptr      top-left input address of the requested tile
//   iwork_f         engine busy flag (observed only, see odbg)
//   idone_f         engine 1-cycle done pulse, idata valid with it
//   idata           engine result pixel
//   odata_wr        compressed pixel to output buffer
//   oaddr_wr        output pixel index (row*lpOUT_W+col)
//   omem_wr_en      1-cycle write strobe
//   odbg            current state and registered engine busy flag
//
// Engine handshake: ostart_work is a request level that stays high with
// ostart_ptr stable until the cycle idone_f is sampled high (that cycle is
// the transfer; idata is taken then), or until the timeout fires. idone_f
// seen while no request is outstanding is ignored.
// ----------------------------------------------------------------------------
module im_compression_ctrl
    import im_compression_pkg::*;
#(
    parameter  int pIN_IM_WIDTH  = 640,
    parameter  int pIN_IM_HEIGHT = 480,
    parameter  int pAREA_WIDTH   = 4,
    parameter  int pAREA_HEIGHT  = 4,
    parameter  int pDATA_W       = 24,
    parameter  int pTIMEOUT      = 64,
    localparam int lpOUT_W       = out_dim(pIN_IM_WIDTH, pAREA_WIDTH),
    localparam int lpOUT_H       = out_dim(pIN_IM_HEIGHT, pAREA_HEIGHT),
    localparam int lpC2_IN       = cnt_w(pIN_IM_WIDTH * pIN_IM_HEIGHT),
    localparam int lpC2_OUT      = cnt_w(lpOUT_W * lpOUT_H)
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                istart_frame,
    input  logic [lpC2_IN-1:0]  iframe_base,
    input  logic                iabort,
    output logic                oframe_busy,
    output logic                oframe_done,
    output logic                oerr_timeout,
    output logic                ostart_work,
    output logic [lpC2_IN-1:0]  ostart_ptr,
    input  logic                iwork_f,
    input  logic                idone_f,
    input  logic [pDATA_W-1:0]  idata,
    output logic [pDATA_W-1:0]  odata_wr,
    output logic [lpC2_OUT-1:0] oaddr_wr,
    output logic                omem_wr_en,
    output t_cmp_ctrl_dbg       odbg
);

    localparam int                 lpTMO_W    = cnt_w(pTIMEOUT);
    localparam logic [lpTMO_W-1:0] lpTMO_LAST = lpTMO_W'(pTIMEOUT - 1);

    t_cmp_ctrl_state     state_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                start_work_q;
    logic [lpC2_IN-1:0]  start_ptr_q;
    logic [pDATA_W-1:0]  data_q;
    logic [lpC2_OUT-1:0] addr_q;
    logic                wr_en_q;
    logic [lpC2_OUT-1:0] wr_idx_q;
    logic [lpTMO_W-1:0]  tmo_q;
    logic                eng_busy_q;

    logic                abort_act;
    logic                addr_load;
    logic                addr_adv;
    logic [lpC2_IN-1:0]  tile_ptr;
    logic                tile_last;

    assign abort_act = iabort && (state_q != ST_IDLE);
    assign addr_load = (state_q == ST_IDLE) && istart_frame && !iabort;
    assign addr_adv  = (state_q == ST_WRITE) && !iabort;

    im_tile_addr_gen #(
        .pIN_IM_WIDTH (pIN_IM_WIDTH),
        .pAREA_WIDTH  (pAREA_WIDTH),
        .pAREA_HEIGHT (pAREA_HEIGHT),
        .pOUT_W       (lpOUT_W),
        .pOUT_H       (lpOUT_H),
        .pADDR_W      (lpC2_IN)
    ) u_addr_gen (
        .clk_i      (iclk),
        .rst_i      (irst),
        .load_i     (addr_load),
        .base_i     (iframe_base),
        .advance_i  (addr_adv),
        .tile_ptr_o (tile_ptr),
        .last_o     (tile_last)
    );

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            start_work_q <= 1'b0;
            start_ptr_q  <= '0;
            data_q       <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_idx_q     <= '0;
            tmo_q        <= '0;
            eng_busy_q   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            done_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            eng_busy_q <= iwork_f;
            if (abort_act) begin
                // Abort drops any outstanding job or write and never pulses done.
                state_q      <= ST_IDLE;
                start_work_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (istart_frame && !iabort) begin
                            busy_q   <= 1'b1;
                            err_q    <= 1'b0;
                            wr_idx_q <= '0;
                            state_q  <= ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        start_ptr_q  <= tile_ptr;
                        start_work_q <= 1'b1;
                        tmo_q        <= '0;
                        state_q      <= ST_WAIT_DONE;
                    end
                    ST_WAIT_DONE: begin
                        if (idone_f) begin
                            // Write strobe is raised on entry to WRITE so it
                            // appears exactly one cycle after the done pulse.
                            data_q       <= idata;
                            addr_q       <= wr_idx_q;
                            wr_en_q      <= 1'b1;
                            start_work_q <= 1'b0;
                            state_q      <= ST_WRITE;
                        end else if (tmo_q == lpTMO_LAST) begin
                            start_work_q <= 1'b0;
                            err_q        <= 1'b1;
                            done_q       <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            tmo_q <= tmo_q + lpTMO_W'(1);
                        end
                    end
                    ST_WRITE: begin
                        wr_idx_q <= wr_idx_q + lpC2_OUT'(1);
                        if (tile_last) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign oframe_busy  = busy_q;
    assign oframe_done  = done_q;
    assign oerr_timeout = err_q;
    assign ostart_work  = start_work_q;
    assign ostart_ptr   = start_ptr_q;
    assign odata_wr     = data_q;
    assign oaddr_wr     = addr_q;
    assign omem_wr_en   = wr_en_q;

    always_comb begin
        odbg             = '0;
        odbg.state       = state_q;
        odbg.engine_busy = eng_busy_q;
    end

endmodule

// File: tb/tb_im_compression_ctrl.sv
// ----------------------------------------------------------------------------
// tb_im_compression_ctrl
// Small-frame bench (16x8 pixels, 4x4 tiles -> 4x2 output grid). An engine
// model answers each job after a random latency with random data; a monitor
// records writes, job issues and done pulses; directed steps compare those
// records against a frame-level reference computed from the raster rules.
// ----------------------------------------------------------------------------
module tb_im_compression_ctrl;
    import im_compression_pkg::*;

    localparam int W      = 16;
    localparam int H      = 8;
    localparam int AW     = 4;
    localparam int AH     = 4;
    localparam int DW     = 24;
    localparam int TMO    = 64;
    localparam int OW     = W / AW;
    localparam int OH     = H / AH;
    localparam int NT     = OW * OH;
    localparam int C2_IN  = $clog2(W * H);
    localparam int C2_OUT = $clog2(OW * OH);
    // Largest base whose last tile still fits in the input address space.
    localparam int MAX_BASE = (1 << C2_IN) - 1 - ((OH - 1) * AH * W + (OW - 1) * AW) - (AH - 1) * W - (AW - 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              istart_frame, iabort, iwork_f, idone_f;
    logic [C2_IN-1:0]  iframe_base;
    logic [DW-1:0]     idata;
    logic              oframe_busy, oframe_done, oerr_timeout, ostart_work, omem_wr_en;
    logic [C2_IN-1:0]  ostart_ptr;
    logic [DW-1:0]     odata_wr;
    logic [C2_OUT-1:0] oaddr_wr;
    t_cmp_ctrl_dbg     odbg;

    im_compression_ctrl #(
        .pIN_IM_WIDTH (W),
        .pIN_IM_HEIGHT(H),
        .pAREA_WIDTH  (AW),
        .pAREA_HEIGHT (AH),
        .pDATA_W      (DW),
        .pTIMEOUT     (TMO)
    ) dut (
        .iclk        (clk),
        .irst        (rst),
        .istart_frame(istart_frame),
        .iframe_base (iframe_base),
        .iabort      (iabort),
        .oframe_busy (oframe_busy),
        .oframe_done (oframe_done),
        .oerr_timeout(oerr_timeout),
        .ostart_work (ostart_work),
        .ostart_ptr  (ostart_ptr),
        .iwork_f     (iwork_f),
        .idone_f     (idone_f),
        .idata       (idata),
        .odata_wr    (odata_wr),
        .oaddr_wr    (oaddr_wr),
        .omem_wr_en  (omem_wr_en),
        .odbg        (odbg)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [C2_OUT-1:0] wr_addr_q[$];
    logic [DW-1:0]     wr_data_q[$];
    int                wr_cyc_q[$];
    logic [C2_IN-1:0]  ptr_q[$];
    int                rise_cyc_q[$];
    logic [DW-1:0]     eng_data_q[$];
    int                eng_cyc_q[$];
    logic [C2_IN-1:0]  exp_q[$];
    int                done_cnt = 0;
    int                fall_cyc = 0;
    int                cyc      = 0;
    logic              prev_sw  = 1'b0;

    // engine controls (written by the directed steps only)
    logic eng_en   = 1'b1;
    logic fixed_en = 1'b0;
    int   lat_lo   = 1;
    int   lat_hi   = 1;
    int   stray_cnt = 0;

    // ---------------- monitor + engine model ----------------
    initial begin : env_blk
        logic eng_busy;
        int   eng_left;
        int   stray_served;
        eng_busy = 1'b0; eng_left = 0; stray_served = 0;
        idone_f = 1'b0; iwork_f = 1'b0; idata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_sw = 1'b0;
            end else begin
                if (omem_wr_en) begin
                    wr_addr_q.push_back(oaddr_wr);
                    wr_data_q.push_back(odata_wr);
                    wr_cyc_q.push_back(cyc);
                end
                if (ostart_work && !prev_sw) begin
                    ptr_q.push_back(ostart_ptr);
                    rise_cyc_q.push_back(cyc);
                end
                if (!ostart_work && prev_sw) fall_cyc = cyc;
                if (oframe_done) done_cnt++;
                prev_sw = ostart_work;
            end
            idone_f = 1'b0;
            if (rst) begin
                eng_busy = 1'b0;
                iwork_f  = 1'b0;
            end else if (stray_served != stray_cnt) begin
                stray_served = stray_cnt;
                idone_f = 1'b1;
                idata   = DW'($urandom);
            end else if (eng_busy) begin
                if (eng_left == 0) begin
                    eng_busy = 1'b0;
                    iwork_f  = 1'b0;
                    idone_f  = 1'b1;
                    idata    = fixed_en ? 24'hA5B6C7 : DW'($urandom);
                    if (ostart_work) begin
                        eng_data_q.push_back(idata);
                        eng_cyc_q.push_back(cyc);
                    end
                end else begin
                    eng_left--;
                end
            end else if (eng_en && ostart_work) begin
                eng_busy = 1'b1;
                iwork_f  = 1'b1;
                eng_left = $urandom_range(lat_hi, lat_lo);
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},  32'(oframe_busy),  0);
        chk({pfx, "_done"},  32'(oframe_done),  0);
        chk({pfx, "_err"},   32'(oerr_timeout), 0);
        chk({pfx, "_work"},  32'(ostart_work),  0);
        chk({pfx, "_ptr"},   32'(ostart_ptr),   0);
        chk({pfx, "_data"},  32'(odata_wr),     0);
        chk({pfx, "_addr"},  32'(oaddr_wr),     0);
        chk({pfx, "_wren"},  32'(omem_wr_en),   0);
    endtask

    // Reference: tile k of the raster walk starts AH input rows per tile row
    // and AW pixels per tile column from the frame base.
    task automatic build_expected(input int base);
        exp_q.delete();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                exp_q.push_back(C2_IN'(base + r * AH * W + c * AW));
    endtask

    task automatic wait_done(input int db, input int bound);
        int n;
        n = 0;
        while (done_cnt == db && n < bound) begin
            tick();
            n++;
        end
        chk("done_within_bound", 32'(done_cnt != db), 1);
    endtask

    task automatic check_frame(input int base, input int wb, input int pb, input int eb, input int db);
        int nw, np, ne;
        nw = wr_addr_q.size() - wb;
        np = ptr_q.size() - pb;
        ne = eng_data_q.size() - eb;
        chk("write_count", 32'(nw), NT);
        chk("issue_count", 32'(np), NT);
        chk("done_count", 32'(done_cnt - db), 1);
        chk("err_clear", 32'(oerr_timeout), 0);
        chk("busy_low", 32'(oframe_busy), 0);
        build_expected(base);
        for (int k = 0; k < NT; k++) begin
            logic [C2_IN-1:0] exp_ptr;
            exp_ptr = exp_q.pop_front();
            if (k < np) chk("start_ptr", 32'(ptr_q[pb + k]), 32'(exp_ptr));
            if (k < nw) begin
                chk("wr_addr", 32'(wr_addr_q[wb + k]), 32'(k));
                if (k < ne) begin
                    chk("wr_data", 32'(wr_data_q[wb + k]), 32'(eng_data_q[eb + k]));
                    chk("done_to_wr", 32'(wr_cyc_q[wb + k] - eng_cyc_q[eb + k]), 1);
                end
            end
            // Done sampled at edge E; write cycle, issue cycle, then the new
            // request is visible after edge E+2 (third sample point).
            if (k + 1 < np && k < ne)
                chk("done_to_issue", 32'(rise_cyc_q[pb + k + 1] - eng_cyc_q[eb + k]), 3);
        end
    endtask

    task automatic run_and_check(input int base, input bit poke_busy);
        int wb, pb, eb, db;
        wb = wr_addr_q.size(); pb = ptr_q.size(); eb = eng_data_q.size(); db = done_cnt;
        iframe_base  = C2_IN'(base);
        istart_frame = 1'b1;
        tick();
        istart_frame = 1'b0;
        chk("busy_after_start", 32'(oframe_busy), 1);
        chk("err_after_start", 32'(oerr_timeout), 0);
        if (poke_busy) begin
            repeat (10) tick();
            iframe_base  = C2_IN'(base + 3);
            istart_frame = 1'b1;
            tick();
            istart_frame = 1'b0;
        end
        wait_done(db, NT * (lat_hi + 8) + 40);
        tick();
        check_frame(base, wb, pb, eb, db);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main_blk
        int wb, pb, db, n;
        rst = 1'b1; istart_frame = 1'b0; iabort = 1'b0; iframe_base = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();

        // Raster walk with a 20-cycle engine.
        lat_lo = 20; lat_hi = 20;
        run_and_check(0, 1'b0);

        // Random bases and latencies, one with a start pulse while busy.
        for (int f = 0; f < 3; f++) begin
            lat_lo = $urandom_range(4, 0);
            lat_hi = lat_lo + $urandom_range(12, 0);
            run_and_check($urandom_range(MAX_BASE, 0), f == 1);
        end

        // Fixed engine result pattern.
        fixed_en = 1'b1; lat_lo = 2; lat_hi = 2;
        wb = wr_addr_q.size();
        run_and_check($urandom_range(MAX_BASE, 0), 1'b0);
        chk("fixed_data", 32'(wr_data_q[wb]), 32'h00A5B6C7);
        fixed_en = 1'b0;

        // Stray done pulse while idle.
        wb = wr_addr_q.size();
        stray_cnt++;
        repeat (4) tick();
        chk("stray_no_write", 32'(wr_addr_q.size() - wb), 0);
        chk("stray_idle", 32'(oframe_busy), 0);

        // Engine never answers: timeout.
        eng_en = 1'b0;
        wb = wr_addr_q.size(); pb = ptr_q.size(); db = done_cnt;
        iframe_base = C2_IN'(9); istart_frame = 1'b1;
        tick();
        istart_frame = 1'b0;
        wait_done(db, TMO + 40);
        chk("tmo_err", 32'(oerr_timeout), 1);
        chk("tmo_one_issue", 32'(ptr_q.size() - pb), 1);
        if (ptr_q.size() > pb) chk("tmo_len", 32'(fall_cyc - rise_cyc_q[pb]), TMO);
        chk("tmo_no_write", 32'(wr_addr_q.size() - wb), 0);
        tick();
        chk("tmo_done_once", 32'(done_cnt - db), 1);
        chk("tmo_busy_low", 32'(oframe_busy), 0);
        chk("tmo_sticky", 32'(oerr_timeout), 1);
        eng_en = 1'b1;
        lat_lo = 1; lat_hi = 6;
        run_and_check($urandom_range(MAX_BASE, 0), 1'b0);

        // Abort while the third tile is in flight, then restart.
        lat_lo = 3; lat_hi = 3;
        wb = wr_addr_q.size(); pb = ptr_q.size(); db = done_cnt;
        iframe_base = C2_IN'(5); istart_frame = 1'b1;
        tick();
        istart_frame = 1'b0;
        n = 0;
        while ((wr_addr_q.size() - wb < 2 || !ostart_work) && n < 200) begin
            tick();
            n++;
        end
        chk("abort_on_tile3", 32'(ptr_q.size() - pb), 3);
        iabort = 1'b1;
        tick();
        chk("abort_busy", 32'(oframe_busy), 0);
        chk("abort_work", 32'(ostart_work), 0);
        chk("abort_wren", 32'(omem_wr_en), 0);
        iabort = 1'b0;
        repeat (40) tick();
        chk("abort_writes", 32'(wr_addr_q.size() - wb), 2);
        chk("abort_no_done", 32'(done_cnt - db), 0);
        chk("abort_no_issue", 32'(ptr_q.size() - pb), 3);
        lat_lo = 0; lat_hi = 8;
        run_and_check($urandom_range(MAX_BASE, 0), 1'b0);

        // Start and abort together while idle.
        pb = ptr_q.size();
        iframe_base = C2_IN'(3); istart_frame = 1'b1; iabort = 1'b1;
        tick();
        istart_frame = 1'b0; iabort = 1'b0;
        chk("startabort_busy", 32'(oframe_busy), 0);
        repeat (5) tick();
        chk("startabort_work", 32'(ostart_work), 0);
        chk("startabort_no_issue", 32'(ptr_q.size() - pb), 0);

        // Asynchronous reset while waiting for the engine.
        eng_en = 1'b0;
        db = done_cnt;
        iframe_base = C2_IN'(41); istart_frame = 1'b1;
        tick();
        istart_frame = 1'b0;
        repeat (6) tick();
        chk("pre_reset_work", 32'(ostart_work), 1);
        chk("pre_reset_ptr", 32'(ostart_ptr), 41);
        #2 rst = 1'b1;
        #1;
        chk_zero("async_rst");
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_no_done", 32'(done_cnt - db), 0);
        chk("rst_idle", 32'(oframe_busy), 0);
        eng_en = 1'b1;
        lat_lo = 0; lat_hi = 5;
        run_and_check($urandom_range(MAX_BASE, 0), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
